// File: rtl/locked_reg_pkg.sv
// rtl/locked_reg_pkg.sv - shared types and constants for the lockable register bank
package locked_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        OPEN,
        LOCKOUT
    } unlock_state_t;

    localparam logic [15:0] DEFAULT_UNLOCK_KEY = 16'hA5C3;

endpackage

// File: rtl/debug_unlock_fsm.sv
// rtl/debug_unlock_fsm.sv - two-key debug unlock sequencer with timeout and terminal lockout
module debug_unlock_fsm
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] UNLOCK_KEY = DEFAULT_UNLOCK_KEY,
    parameter int               UNLOCK_TMO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             debug_mode,
    input  logic             trusted,
    input  logic             key_valid,
    input  logic [WIDTH-1:0] key_in,
    output logic             unlock_open,
    output logic             unlock_fail
);

    localparam int               CNT_W = $clog2(UNLOCK_TMO + 1);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(UNLOCK_TMO);
    localparam logic [WIDTH-1:0] KEY2  = ~UNLOCK_KEY;

    unlock_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             open_q, open_d;
    logic             fail_q, fail_d;
    logic             auth;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auth    = debug_mode & trusted;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    if (auth && key_in == UNLOCK_KEY) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
            end
            ARMED: begin
                // Saturating, so cnt_q != TMO is the same as cnt_q < TMO.
                if (cnt_q != TMO) cnt_d = cnt_q + CNT_W'(1);
                if (!auth || cnt_q == TMO) begin
                    state_d = IDLE;
                end else if (key_valid) begin
                    state_d = (key_in == KEY2) ? OPEN : LOCKOUT;
                end
            end
            OPEN: begin
                if (!auth || key_valid) state_d = IDLE;
            end
            default: state_d = LOCKOUT;
        endcase
        open_d = (state_d == OPEN);
        fail_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            open_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            fail_q  <= fail_d;
        end
    end

    assign unlock_open = open_q;
    assign unlock_fail = fail_q;

endmodule

// File: rtl/locked_register_bank.sv
// rtl/locked_register_bank.sv - bank of sticky-lockable config registers with debug unlock window
module locked_register_bank
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               NUM_REGS   = 4,
    parameter int               ADDR_W     = $clog2(NUM_REGS),
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] UNLOCK_KEY = DEFAULT_UNLOCK_KEY,
    parameter int               UNLOCK_TMO = 8
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WIDTH-1:0]    Data_in,
    input  logic                Lock,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [WIDTH-1:0]    Data_out,
    output logic [NUM_REGS-1:0] lock_status,
    output logic                write_err,
    input  logic                debug_mode,
    input  logic                trusted,
    input  logic                key_valid,
    input  logic [WIDTH-1:0]    key_in,
    output logic                unlock_open,
    output logic                unlock_fail
);

    localparam logic [ADDR_W:0] NUM_W = (ADDR_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d;
    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic                write_err_q, write_err_d;
    logic                wr_in_range, rd_in_range, wr_ok;

    debug_unlock_fsm #(
        .WIDTH      (WIDTH),
        .UNLOCK_KEY (UNLOCK_KEY),
        .UNLOCK_TMO (UNLOCK_TMO)
    ) u_unlock (
        .clk         (Clk),
        .reset       (reset),
        .debug_mode  (debug_mode),
        .trusted     (trusted),
        .key_valid   (key_valid),
        .key_in      (key_in),
        .unlock_open (unlock_open),
        .unlock_fail (unlock_fail)
    );

    always_comb begin
        regs_d      = regs_q;
        lock_d      = lock_q;
        wr_in_range = ({1'b0, addr} < NUM_W);
        rd_in_range = ({1'b0, rd_addr} < NUM_W);
        // Old lock value qualifies the write, so a same-cycle write+Lock still lands.
        wr_ok       = write & wr_in_range & (~lock_q[addr] | unlock_open);
        if (wr_ok) regs_d[addr] = Data_in;
        if (Lock && wr_in_range) lock_d[addr] = 1'b1;
        write_err_d = write & ~wr_ok;
        data_out_d  = rd_in_range ? regs_q[rd_addr] : '0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            lock_q      <= '0;
            data_out_q  <= RESET_VAL;
            write_err_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            lock_q      <= lock_d;
            data_out_q  <= data_out_d;
            write_err_q <= write_err_d;
        end
    end

    assign Data_out    = data_out_q;
    assign lock_status = lock_q;
    assign write_err   = write_err_q;

endmodule
